// File: rtl/xs3_pkg.sv
// rtl/xs3_pkg.sv - shared constants and state type for the Excess-3 decoder
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET  = 4'h3;
  localparam logic [3:0] XS3_MIN     = 4'h3;
  localparam logic [3:0] XS3_MAX     = 4'hC;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

endpackage

// File: rtl/xs3_digit_dec.sv
// rtl/xs3_digit_dec.sv - combinational single-digit Excess-3 to BCD decoder
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] xs3,
  output logic [3:0] bcd,
  output logic       invalid
);

  // Codes outside 3..C have no BCD meaning and are forced to BCD_INVALID.
  always_comb begin
    invalid = (xs3 < XS3_MIN) || (xs3 > XS3_MAX);
    bcd     = invalid ? BCD_INVALID : (xs3 - XS3_OFFSET);
  end

endmodule

// File: rtl/excess3_to_bcd_seq.sv
// rtl/excess3_to_bcd_seq.sv - digit-serial Excess-3 to packed-BCD decoder with valid/ready
module excess3_to_bcd_seq
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_xs3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [DIGITS-1:0]   out_err_mask,
  output logic                out_err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic [3:0]      dig_bcd;
  logic            dig_inv;

  // The shift register always presents the next digit to decode at its LSBs.
  xs3_digit_dec u_dec (
    .xs3     (shift_q[3:0]),
    .bcd     (dig_bcd),
    .invalid (dig_inv)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_xs3;
          bcd_d   = '0;
          mask_d  = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) begin
            bcd_d[4*i +: 4] = dig_bcd;
            mask_d[i]       = dig_inv;
          end
        end
        shift_d = shift_q >> 4;
        if (idx_q == IW'(DIGITS - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      mask_q  <= mask_d;
    end
  end

  // Handshake flags decode straight from the state register so reset drops out_valid at once.
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_bcd      = bcd_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;

endmodule

// File: tb/tb_excess3_to_bcd_seq.sv
// tb/tb_excess3_to_bcd_seq.sv - randomized self-checking bench for excess3_to_bcd_seq
module tb_excess3_to_bcd_seq;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_xs3, out_bcd;
  logic [3:0]  out_err_mask;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
  logic [3:0]  in_xs31, out_bcd1;
  logic [0:0]  out_err_mask1;

  int n_vec = 0;
  int n_err = 0;

  excess3_to_bcd_seq #(.DIGITS(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_xs3       (in_xs3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
  );

  excess3_to_bcd_seq #(.DIGITS(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid1),
    .in_ready     (in_ready1),
    .in_xs3       (in_xs31),
    .out_valid    (out_valid1),
    .out_ready    (out_ready1),
    .out_bcd      (out_bcd1),
    .out_err_mask (out_err_mask1),
    .out_err      (out_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: each nibble taken as a number; 3..12 map to value-3, everything else to 15.
  function automatic logic [15:0] exp_bcd(input logic [15:0] w, input int nd);
    logic [15:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      int d = (int'(w) >> (4 * i)) % 16;
      int v = (d >= 3 && d <= 12) ? d - 3 : 15;
      r = r | 16'(v << (4 * i));
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [15:0] w, input int nd);
    logic [3:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      int d = (int'(w) >> (4 * i)) % 16;
      if (d < 3 || d > 12) r = r | 4'(1 << i);
    end
    return r;
  endfunction

  task automatic run4(input logic [15:0] w, input int hold, input bit junk);
    logic [15:0] eb;
    logic [3:0]  em;
    eb = exp_bcd(w, 4);
    em = exp_mask(w, 4);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_xs3   = w;
    @(posedge clk); #1;
    if (junk) in_xs3 = 16'($urandom); else in_valid = 1'b0;
    chk("in_ready_conv", 32'(in_ready), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      if (junk) in_xs3 = 16'($urandom);
    end
    chk("valid_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("valid", 32'(out_valid), 32'd1);
    chk("bcd", 32'(out_bcd), 32'(eb));
    chk("mask", 32'(out_err_mask), 32'(em));
    chk("err", 32'(out_err), 32'(em != 4'd0));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_bcd", 32'(out_bcd), 32'(eb));
      chk("hold_mask", 32'(out_err_mask), 32'(em));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd1);
    chk("post_bcd", 32'(out_bcd), 32'(eb));
  endtask

  task automatic run1(input logic [3:0] c);
    logic [15:0] eb;
    logic [3:0]  em;
    eb = exp_bcd(16'(c), 1);
    em = exp_mask(16'(c), 1);
    in_valid1 = 1'b1;
    in_xs31   = c;
    @(posedge clk); #1;
    in_xs31 = 4'($urandom);
    chk("d1_valid_early", 32'(out_valid1), 32'd0);
    @(posedge clk); #1;
    chk("d1_valid", 32'(out_valid1), 32'd1);
    chk("d1_bcd", 32'(out_bcd1), 32'(eb));
    chk("d1_err", 32'(out_err1), 32'(em[0]));
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("d1_post_ready", 32'(in_ready1), 32'd1);
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0;
    in_valid = 1'b0; in_xs3 = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_xs31 = '0; out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_bcd", 32'(out_bcd), 32'd0);
    chk("rst_mask", 32'(out_err_mask), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_d1_valid", 32'(out_valid1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run4(16'h7654, 0, 1'b0);
    chk("dir_7654", 32'(out_bcd), 32'h4321);
    run4(16'h3C3C, 0, 1'b0);
    chk("dir_3c3c", 32'(out_bcd), 32'h0909);
    run4(16'h4F32, 0, 1'b0);
    chk("dir_4f32_bcd", 32'(out_bcd), 32'h1F0F);
    chk("dir_4f32_mask", 32'(out_err_mask), 32'b0101);
    run4(16'h9876, 10, 1'b0);
    run4(16'hC3A5, 0, 1'b1);

    in_valid = 1'b1;
    in_xs3   = 16'h5A5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_bcd", 32'(out_bcd), 32'd0);
    #1;
    rst_n = 1'b1;
    run4(16'h3333, 0, 1'b0);
    chk("after_rst_3333", 32'(out_bcd), 32'h0000);

    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 16; c++) begin
        w = 16'($urandom);
        w[4*p +: 4] = 4'(c);
        run4(w, $urandom_range(0, 2), (c % 2) == 1);
      end
    end
    for (int c = 0; c < 16; c++) begin
      run1(4'(c));
    end
    for (int k = 0; k < 40; k++) begin
      run4(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
